// File: rtl/crop_norm_scheduler.sv
// Per-frame sequencer for NUM_CROPS parallel crop_norm instances sharing one Mono8 pixel stream.
// Latches crop coordinates, fires start pulses, tracks the pixel position and gathers ap_done.
module crop_norm_scheduler #(
  parameter  int IN_ROWS       = 20,
  parameter  int IN_COLS       = 20,
  parameter  int NUM_CROPS     = 2,
  parameter  int DRAIN_TIMEOUT = 1024,
  localparam int CW            = $clog2(IN_COLS),
  localparam int RW            = $clog2(IN_ROWS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      coord_valid,
  output logic                      coord_ready,
  input  logic [NUM_CROPS*CW-1:0]   coord_x0,
  input  logic [NUM_CROPS*RW-1:0]   coord_y0,
  output logic [NUM_CROPS*CW-1:0]   crop_x0,
  output logic [NUM_CROPS*RW-1:0]   crop_y0,
  input  logic                      seq_ap_idle,
  output logic                      seq_ap_start,
  input  logic [NUM_CROPS-1:0]      cn_ap_ready,
  input  logic [NUM_CROPS-1:0]      cn_ap_done,
  output logic [NUM_CROPS-1:0]      cn_ap_start,
  output logic                      all_crop_norm_ap_ready,
  input  logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [CW-1:0]             cnt_col,
  output logic [RW-1:0]             cnt_row,
  output logic                      frame_done,
  output logic [15:0]               frame_count,
  output logic [1:0]                err
);

  localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

  state_t                    r_state;
  logic [NUM_CROPS*CW-1:0]   r_crop_x0;
  logic [NUM_CROPS*RW-1:0]   r_crop_y0;
  logic                      r_seq_start;
  logic [NUM_CROPS-1:0]      r_cn_start;
  logic [CW-1:0]             r_cnt_col;
  logic [RW-1:0]             r_cnt_row;
  logic [NUM_CROPS-1:0]      r_done_mask;
  logic [TW-1:0]             r_tmo;
  logic                      r_frame_done;
  logic [15:0]               r_frame_count;
  logic [1:0]                r_err;

  logic w_beat;
  logic w_all_ready;
  logic w_start_ok;
  logic w_last_col;
  logic w_last_beat;
  logic w_done_all;
  logic w_tmo_hit;
  logic w_proto_err;

  assign w_beat      = pix_valid & pix_ready;
  assign w_all_ready = &cn_ap_ready;
  assign w_start_ok  = w_all_ready & seq_ap_idle;
  assign w_last_col  = (r_cnt_col == CW'(IN_COLS - 1));
  assign w_last_beat = w_last_col && (r_cnt_row == RW'(IN_ROWS - 1));
  // A done landing in the same cycle as the completion check still counts.
  assign w_done_all  = &(r_done_mask | cn_ap_done);
  assign w_tmo_hit   = (r_tmo == TW'(DRAIN_TIMEOUT - 1));
  assign w_proto_err = (((r_state == S_IDLE) || (r_state == S_ARM)) && (w_beat || (|cn_ap_done)))
                     || ((r_state == S_DRAIN) && w_beat);

  // NOTE: every register here is updated with <= so all of them sample pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_crop_x0     <= '0;
      r_crop_y0     <= '0;
      r_seq_start   <= 1'b0;
      r_cn_start    <= '0;
      r_cnt_col     <= '0;
      r_cnt_row     <= '0;
      r_done_mask   <= '0;
      r_tmo         <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_err         <= '0;
    end else begin
      r_seq_start  <= 1'b0;
      r_cn_start   <= '0;
      r_frame_done <= 1'b0;
      if (w_proto_err) r_err[0] <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (coord_valid) begin
            r_crop_x0 <= coord_x0;
            r_crop_y0 <= coord_y0;
            r_state   <= S_ARM;
          end
        end
        S_ARM: begin
          if (w_start_ok) begin
            r_seq_start <= 1'b1;
            r_cn_start  <= '1;
            r_cnt_col   <= '0;
            r_cnt_row   <= '0;
            r_done_mask <= '0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_done_mask <= r_done_mask | cn_ap_done;
          if (w_beat) begin
            if (w_last_beat) begin
              r_cnt_col <= '0;
              r_cnt_row <= '0;
              r_tmo     <= '0;
              r_state   <= S_DRAIN;
            end else if (w_last_col) begin
              r_cnt_col <= '0;
              r_cnt_row <= r_cnt_row + 1'b1;
            end else begin
              r_cnt_col <= r_cnt_col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_done_all) begin
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_state       <= S_IDLE;
          end else begin
            r_done_mask <= r_done_mask | cn_ap_done;
            if (w_tmo_hit) begin
              r_err[1] <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign coord_ready            = (r_state == S_IDLE);
  assign all_crop_norm_ap_ready = w_all_ready;
  assign crop_x0                = r_crop_x0;
  assign crop_y0                = r_crop_y0;
  assign seq_ap_start           = r_seq_start;
  assign cn_ap_start            = r_cn_start;
  assign cnt_col                = r_cnt_col;
  assign cnt_row                = r_cnt_row;
  assign frame_done             = r_frame_done;
  assign frame_count            = r_frame_count;
  assign err                    = r_err;

endmodule

// File: tb/tb_crop_norm_scheduler.sv
// Self-checking bench for crop_norm_scheduler (4x4 image, 2 crops, drain timeout 8).
// A frame-level reference model (beat index, done set, drain age) predicts every output each cycle.
module tb_crop_norm_scheduler;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int NC     = 2;
  localparam int TMO    = 8;
  localparam int CW     = 2;
  localparam int RW     = 2;
  localparam int NBEATS = ROWS * COLS;

  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               coord_valid;
  logic               coord_ready;
  logic [NC*CW-1:0]   coord_x0;
  logic [NC*RW-1:0]   coord_y0;
  logic [NC*CW-1:0]   crop_x0;
  logic [NC*RW-1:0]   crop_y0;
  logic               seq_ap_idle;
  logic               seq_ap_start;
  logic [NC-1:0]      cn_ap_ready;
  logic [NC-1:0]      cn_ap_done;
  logic [NC-1:0]      cn_ap_start;
  logic               all_crop_norm_ap_ready;
  logic               pix_valid;
  logic               pix_ready;
  logic [CW-1:0]      cnt_col;
  logic [RW-1:0]      cnt_row;
  logic               frame_done;
  logic [15:0]        frame_count;
  logic [1:0]         err;

  crop_norm_scheduler #(
    .IN_ROWS       (ROWS),
    .IN_COLS       (COLS),
    .NUM_CROPS     (NC),
    .DRAIN_TIMEOUT (TMO)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .coord_valid            (coord_valid),
    .coord_ready            (coord_ready),
    .coord_x0               (coord_x0),
    .coord_y0               (coord_y0),
    .crop_x0                (crop_x0),
    .crop_y0                (crop_y0),
    .seq_ap_idle            (seq_ap_idle),
    .seq_ap_start           (seq_ap_start),
    .cn_ap_ready            (cn_ap_ready),
    .cn_ap_done             (cn_ap_done),
    .cn_ap_start            (cn_ap_start),
    .all_crop_norm_ap_ready (all_crop_norm_ap_ready),
    .pix_valid              (pix_valid),
    .pix_ready              (pix_ready),
    .cnt_col                (cnt_col),
    .cnt_row                (cnt_row),
    .frame_done             (frame_done),
    .frame_count            (frame_count),
    .err                    (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frame progress as a beat index, a set of finished crops and a drain age.
  int               m_phase = P_IDLE;
  logic [NC*CW-1:0] m_cx    = '0;
  logic [NC*RW-1:0] m_cy    = '0;
  bit               m_start = 1'b0;
  bit               m_fdone = 1'b0;
  int               m_beats = 0;
  int               m_drain = 0;
  logic [15:0]      m_fc    = '0;
  logic [1:0]       m_err   = '0;
  logic [NC-1:0]    m_dmask = '0;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_cx    = '0;
    m_cy    = '0;
    m_start = 1'b0;
    m_fdone = 1'b0;
    m_beats = 0;
    m_drain = 0;
    m_fc    = '0;
    m_err   = '0;
    m_dmask = '0;
  endtask

  task automatic model_clock();
    bit beat;
    beat    = pix_valid && pix_ready;
    m_start = 1'b0;
    m_fdone = 1'b0;
    case (m_phase)
      P_IDLE: begin
        if (beat || (cn_ap_done != 0)) m_err[0] = 1'b1;
        if (coord_valid) begin
          m_cx    = coord_x0;
          m_cy    = coord_y0;
          m_phase = P_ARM;
        end
      end
      P_ARM: begin
        if (beat || (cn_ap_done != 0)) m_err[0] = 1'b1;
        if ((cn_ap_ready == {NC{1'b1}}) && seq_ap_idle) begin
          m_start = 1'b1;
          m_beats = 0;
          m_dmask = '0;
          m_phase = P_RUN;
        end
      end
      P_RUN: begin
        m_dmask = m_dmask | cn_ap_done;
        if (beat) begin
          m_beats++;
          if (m_beats == NBEATS) begin
            m_beats = 0;
            m_drain = 0;
            m_phase = P_DRAIN;
          end
        end
      end
      default: begin
        if (beat) m_err[0] = 1'b1;
        m_dmask = m_dmask | cn_ap_done;
        if (m_dmask == {NC{1'b1}}) begin
          m_fdone = 1'b1;
          m_fc    = m_fc + 16'd1;
          m_phase = P_IDLE;
        end else begin
          m_drain++;
          if (m_drain == TMO) begin
            m_err[1] = 1'b1;
            m_phase  = P_IDLE;
          end
        end
      end
    endcase
  endtask

  // Advance one clock: model consumes the inputs seen at the edge, then inputs may change.
  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_clock();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("coord_ready",  coord_ready,  32'(m_phase == P_IDLE));
      check("crop_x0",      crop_x0,      m_cx);
      check("crop_y0",      crop_y0,      m_cy);
      check("seq_ap_start", seq_ap_start, m_start);
      check("cn_ap_start",  cn_ap_start,  m_start ? 2'b11 : 2'b00);
      check("all_ready",    all_crop_norm_ap_ready, &cn_ap_ready);
      check("cnt_col",      cnt_col,      m_beats % COLS);
      check("cnt_row",      cnt_row,      m_beats / COLS);
      check("frame_done",   frame_done,   m_fdone);
      check("frame_count",  frame_count,  m_fc);
      check("err",          err,          m_err);
    end
  end

  // One frame: handshake, optional arm stall, then beats and dones until the DUT returns to IDLE.
  // d0/d1: cycle index of each instance's done pulse; <0 random, >=1000 never.
  task automatic run_frame(input logic [3:0] cx, input logic [3:0] cy, input int pct,
                           input int stall, input int d0, input int d1, output int ncyc);
    int       c;
    int       budget;
    int       want;
    bit [1:0] sent;
    bit       fire;
    coord_x0    = cx;
    coord_y0    = cy;
    coord_valid = 1'b1;
    seq_ap_idle = 1'b1;
    cn_ap_ready = (stall > 0) ? 2'b01 : 2'b11;
    step();
    coord_valid = 1'b0;
    coord_x0    = 4'($urandom);
    coord_y0    = 4'($urandom);
    for (int s = 0; s < stall; s++) begin
      seq_ap_idle = 1'($urandom_range(1));
      step();
      check("no_early_start", seq_ap_start, 1'b0);
    end
    seq_ap_idle = 1'b1;
    cn_ap_ready = 2'b11;
    step();
    check("start_seq", seq_ap_start, 1'b1);
    check("start_cn",  cn_ap_start,  2'b11);
    c      = 0;
    budget = 300;
    sent   = '0;
    while ((coord_ready !== 1'b1) && (budget > 0)) begin
      if (m_phase == P_RUN) begin
        pix_valid = (pct == 100) || ($urandom_range(99) < 90);
        pix_ready = ($urandom_range(99) < 32'(pct));
      end else begin
        pix_valid = 1'($urandom_range(1));
        pix_ready = 1'b0;
      end
      for (int i = 0; i < NC; i++) begin
        want = (i == 0) ? d0 : d1;
        fire = 1'b0;
        if (!sent[i]) begin
          if (want < 0) fire = (m_phase == P_DRAIN) ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
          else          fire = (c == want);
        end
        cn_ap_done[i] = fire;
        sent[i]       = sent[i] | fire;
      end
      step();
      c++;
      budget--;
    end
    pix_valid  = 1'b0;
    pix_ready  = 1'b0;
    cn_ap_done = '0;
    check("frame_back_idle", coord_ready, 1'b1);
    ncyc = c;
  endtask

  int ncyc;

  initial begin
    coord_valid = 1'b0;
    coord_x0    = '0;
    coord_y0    = '0;
    seq_ap_idle = 1'b1;
    cn_ap_ready = 2'b11;
    cn_ap_done  = '0;
    pix_valid   = 1'b0;
    pix_ready   = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    cmp_en = 1'b1;
    #1;
    check("rst_coord_ready", coord_ready, 1'b1);
    repeat (2) step();
    check("rst_frame_count", frame_count, 16'd0);
    check("rst_err",         err,         2'b00);
    check("rst_cnt",         {cnt_row, cnt_col}, 4'd0);
    reset = 1'b0;
    step();

    // Normal frame with fixed coordinates and dones inside DRAIN.
    run_frame(4'b1001, 4'b0001, 100, 0, 20, 22, ncyc);
    check("t1_cycles",      ncyc,        23);
    check("t1_frame_count", frame_count, 16'd1);
    check("t1_err",         err,         2'b00);
    check("t1_crop_x0",     crop_x0,     4'b1001);
    check("t1_crop_y0",     crop_y0,     4'b0001);

    // Backpressure on pix_ready.
    run_frame(4'($urandom), 4'($urandom), 50, 0, 3, 10, ncyc);
    check("t2_frame_count", frame_count, 16'd2);

    // Arm stall with one instance not ready.
    run_frame(4'($urandom), 4'($urandom), 100, 5, 5, 17, ncyc);
    check("t3_frame_count", frame_count, 16'd3);

    // Drain timeout: instance 1 never finishes.
    run_frame(4'($urandom), 4'($urandom), 100, 0, 2, 1000, ncyc);
    check("t4_cycles",      ncyc,        NBEATS + TMO);
    check("t4_err",         err,         2'b10);
    check("t4_frame_count", frame_count, 16'd3);

    // Protocol error: beat and a stray done while idle.
    pix_valid  = 1'b1;
    pix_ready  = 1'b1;
    cn_ap_done = 2'b10;
    step();
    pix_valid  = 1'b0;
    pix_ready  = 1'b0;
    cn_ap_done = '0;
    step();
    check("t5_err", err, 2'b11);
    check("t5_cnt", {cnt_row, cnt_col}, 4'd0);
    run_frame(4'($urandom), 4'($urandom), 100, 0, -1, 4, ncyc);
    check("t5_frame_count", frame_count, 16'd4);

    // Async reset in the middle of RUN after 7 beats.
    coord_x0    = 4'hF;
    coord_y0    = 4'hA;
    coord_valid = 1'b1;
    step();
    coord_valid = 1'b0;
    cn_ap_ready = 2'b11;
    step();
    pix_valid = 1'b1;
    pix_ready = 1'b1;
    repeat (7) step();
    check("t6_pre_cnt", {cnt_row, cnt_col}, 4'd7);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("t6_coord_ready", coord_ready, 1'b1);
    check("t6_cnt",         {cnt_row, cnt_col}, 4'd0);
    check("t6_crop",        {crop_y0, crop_x0}, 8'd0);
    check("t6_frame_count", frame_count, 16'd0);
    check("t6_err",         err,         2'b00);
    check("t6_starts",      {seq_ap_start, cn_ap_start}, 3'd0);
    pix_valid = 1'b0;
    pix_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    run_frame(4'($urandom), 4'($urandom), 100, 0, 1, 9, ncyc);
    check("t6_frame_count_after", frame_count, 16'd1);
    check("t6_err_after",         err,         2'b00);

    // Randomised frames.
    for (int f = 0; f < 6; f++) begin
      run_frame(4'($urandom), 4'($urandom), 30 + int'($urandom_range(70)),
                int'($urandom_range(3)), -1, -1, ncyc);
    end
    step();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
